// File: rtl/cp_insert_ppb_pkg.sv
// Shared types and helpers for the cyclic-prefix inserter: CP mode codes,
// write/read FSM encodings and CP length selection.
package cp_insert_ppb_pkg;

  localparam logic CP_MODE_SHORT = 1'b0;
  localparam logic CP_MODE_LONG  = 1'b1;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_CP   = 2'd1,
    R_BODY = 2'd2
  } rd_state_t;

  function automatic int unsigned cp_len(input logic mode,
                                         input int unsigned short_len,
                                         input int unsigned long_len);
    return (mode == CP_MODE_LONG) ? long_len : short_len;
  endfunction

endpackage

// File: rtl/cp_insert_ppb_dpram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered (1-cycle) read. The address MSB selects the ping/pong bank.
module cp_insert_ppb_dpram #(
  parameter int W  = 40,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/cp_insert_ppb.sv
// Cyclic-prefix inserter: buffers N-sample symbols in a ping-pong RAM and
// replays the last L samples followed by the whole symbol.
//
// state  | meaning
// W_IDLE | waiting for a start-of-symbol sample
// W_FILL | writing samples 1..N-1 of the current symbol
// R_IDLE | no full bank to play out
// R_CP   | reading prefix addresses N-L..N-1
// R_BODY | reading symbol addresses 0..N-1
module cp_insert_ppb
  import cp_insert_ppb_pkg::*;
#(
  parameter int DW       = 20,
  parameter int NFFT     = 64,
  parameter int CP_SHORT = 16,
  parameter int CP_LONG  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic          cp_mode,
  input  logic [DW-1:0] in_i,
  input  logic [DW-1:0] in_q,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_q,
  output logic          sop_err
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST = AW'(NFFT - 1);

  function automatic logic [AW-1:0] cp_start(input logic mode);
    return AW'(NFFT - int'(cp_len(mode, CP_SHORT, CP_LONG)));
  endfunction

  wr_state_t     wr_state, wr_state_nxt;
  rd_state_t     rd_state, rd_state_nxt;
  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_idx, rd_addr, rd_addr_nxt;
  logic [1:0]    bank_full, bank_mode;
  logic          accept, wr_we, wr_done, sop_restart;
  logic [AW:0]   wr_addr;
  logic          cur_ready, nxt_ready, rd_en, rd_done, rd_first, rd_last;
  logic [2*DW-1:0] ram_q;
  logic          s1_valid, s1_sop, s1_eop, vld_q, sop_q, eop_q;
  logic [DW-1:0] out_i_q, out_q_q;

  assign in_ready = en & ~rst & ~bank_full[wr_bank];
  assign accept   = en & in_valid & in_ready;

  // write FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= W_IDLE;
    else if (en) wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (accept && in_sop) wr_state_nxt = W_FILL;
      W_FILL:  if (accept && !in_sop && wr_idx == LAST) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    wr_we       = accept && (in_sop || wr_state == W_FILL);
    wr_done     = accept && !in_sop && wr_state == W_FILL && wr_idx == LAST;
    sop_restart = accept && in_sop && wr_state == W_FILL;
    wr_addr     = {wr_bank, (in_sop ? {AW{1'b0}} : wr_idx)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      bank_mode <= '0;
    end else if (en) begin
      if (accept && in_sop) begin
        wr_idx             <= AW'(1);
        bank_mode[wr_bank] <= cp_mode;
      end else if (wr_we) begin
        wr_idx <= wr_idx + AW'(1);
      end
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sop_err <= 1'b0;
    else     sop_err <= sop_restart;
  end

  // set and clear always target different banks, so both may act in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_full <= '0;
    else if (en)
      bank_full <= (bank_full | (wr_done ? (2'b01 << wr_bank) : 2'b00))
                   & ~(rd_done ? (2'b01 << rd_bank) : 2'b00);
  end

  // read FSM; a bank completing this cycle is visible without waiting for its flag
  assign cur_ready = bank_full[rd_bank]  | (wr_done & (wr_bank == rd_bank));
  assign nxt_ready = bank_full[~rd_bank] | (wr_done & (wr_bank != rd_bank));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= R_IDLE;
    else if (en) rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    case (rd_state)
      R_IDLE: if (cur_ready) begin
        rd_state_nxt = R_CP;
        rd_addr_nxt  = cp_start(bank_mode[rd_bank]);
      end
      R_CP: if (rd_addr == LAST) begin
        rd_state_nxt = R_BODY;
        rd_addr_nxt  = '0;
      end else rd_addr_nxt = rd_addr + AW'(1);
      R_BODY: if (rd_addr == LAST) begin
        rd_state_nxt = nxt_ready ? R_CP : R_IDLE;
        rd_addr_nxt  = nxt_ready ? cp_start(bank_mode[~rd_bank]) : '0;
      end else rd_addr_nxt = rd_addr + AW'(1);
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_en    = en && rd_state != R_IDLE;
    rd_done  = en && rd_state == R_BODY && rd_addr == LAST;
    rd_first = rd_state == R_CP && rd_addr == cp_start(bank_mode[rd_bank]);
    rd_last  = rd_state == R_BODY && rd_addr == LAST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else if (en) begin
      rd_addr <= rd_addr_nxt;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  cp_insert_ppb_dpram #(.W(2*DW), .AW(AW+1)) u_ram (
    .clk   (clk),
    .we    (wr_we),
    .waddr (wr_addr),
    .wdata ({in_i, in_q}),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr}),
    .q     (ram_q)
  );

  // flags track the RAM read stage, then a common output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      out_i_q  <= '0;
      out_q_q  <= '0;
    end else if (en) begin
      s1_valid <= rd_state != R_IDLE;
      s1_sop   <= rd_first;
      s1_eop   <= rd_last;
      vld_q    <= s1_valid;
      sop_q    <= s1_sop;
      eop_q    <= s1_eop;
      if (s1_valid) {out_i_q, out_q_q} <= ram_q;
    end
  end

  assign out_valid = en & vld_q;
  assign out_sop   = en & sop_q;
  assign out_eop   = en & eop_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;

endmodule

// File: tb/tb_cp_insert_ppb.sv
// Directed bench for cp_insert_ppb: drives symbols, captures the output
// stream and compares it with the expected CP + body sequence.
module tb_cp_insert_ppb;

  localparam int DW = 20;
  localparam int N  = 64;
  localparam int LS = 16;
  localparam int LL = 32;
  localparam logic [DW-1:0] IMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] IMAX = {1'b0, {(DW-1){1'b1}}};

  logic clk = 1'b0;
  logic rst, en, in_valid, in_ready, in_sop, cp_mode;
  logic [DW-1:0] in_i, in_q, out_i, out_q;
  logic out_valid, out_sop, out_eop, sop_err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int stalls = 0;
  int err_pulses = 0;
  int last_acc = 0;
  bit en_tog = 1'b0;
  int phase = 0;

  logic [DW-1:0] cap_i[$], cap_q[$];
  logic cap_sop[$], cap_eop[$];
  int cap_edge[$];

  cp_insert_ppb #(.DW(DW), .NFFT(N), .CP_SHORT(LS), .CP_LONG(LL)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .cp_mode(cp_mode), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_i(out_i), .out_q(out_q), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_i.push_back(out_i);
      cap_q.push_back(out_q);
      cap_sop.push_back(out_sop);
      cap_eop.push_back(out_eop);
      cap_edge.push_back(edge_n);
    end
    if (sop_err) err_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (en_tog) begin
      en = (phase == 0);
      phase = (phase + 1) % 3;
    end else en = 1'b1;
  endtask

  task automatic clear_cap();
    cap_i.delete(); cap_q.delete(); cap_sop.delete(); cap_eop.delete(); cap_edge.delete();
  endtask

  task automatic send_sym(input int n, input logic mode, input int base,
                          input bit sop_first, input bit extreme);
    bit done;
    int budget;
    for (int i = 0; i < n; i++) begin
      done = 1'b0;
      budget = 0;
      in_valid = 1'b1;
      in_sop = sop_first && (i == 0);
      cp_mode = mode;
      if (extreme) begin
        in_i = IMIN;
        in_q = IMAX;
      end else begin
        in_i = DW'(base + i);
        in_q = DW'(-(base + i));
      end
      while (!done && budget < 1000) begin
        #1;
        if (in_ready) begin
          done = 1'b1;
          last_acc = edge_n + 1;
        end else stalls++;
        tick();
        budget++;
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL send_timeout sample %0d: in_ready stayed 0, required 1", i);
      end
    end
    in_valid = 1'b0;
    in_sop = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int b;
    b = 0;
    while (cap_i.size() < n && b < 2000) begin
      tick();
      b++;
    end
    repeat (10) tick();
    checks++;
    if (cap_i.size() !== n) begin
      errors++;
      $display("FAIL %s_count: got %0d samples, required %0d", name, cap_i.size(), n);
    end
  endtask

  task automatic check_sym(input int off, input logic mode, input int base,
                           input bit extreme, input string name);
    int l, idx;
    logic [DW-1:0] ei, eq;
    logic es, ee;
    l = mode ? LL : LS;
    for (int j = 0; j < N + l; j++) begin
      idx = (j < l) ? (N - l + j) : (j - l);
      ei = extreme ? IMIN : DW'(base + idx);
      eq = extreme ? IMAX : DW'(-(base + idx));
      es = (j == 0);
      ee = (j == N + l - 1);
      checks++;
      if (off + j >= cap_i.size()) begin
        errors++;
        $display("FAIL %s_missing: sample %0d absent, required i=%0d", name, j, ei);
        break;
      end
      if ({cap_i[off+j], cap_q[off+j], cap_sop[off+j], cap_eop[off+j]} !== {ei, eq, es, ee}) begin
        errors++;
        $display("FAIL %s_sample %0d: got i=%0h q=%0h sop=%0b eop=%0b, required i=%0h q=%0h sop=%0b eop=%0b",
                 name, j, cap_i[off+j], cap_q[off+j], cap_sop[off+j], cap_eop[off+j], ei, eq, es, ee);
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_sop, out_eop, sop_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready/valid/sop/eop/err=%05b, required 00000",
               {in_ready, out_valid, out_sop, out_eop, sop_err});
    end
    checks++;
    if ({out_i, out_q} !== '0) begin
      errors++;
      $display("FAIL reset_data: got i=%0h q=%0h, required 0", out_i, out_q);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b, required 1", in_ready);
    end
    en = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_en_low: got %0b, required 0", in_ready);
    end
    en = 1'b1;
  endtask

  task automatic test_single();
    int acc;
    clear_cap();
    send_sym(N, 1'b0, 0, 1'b1, 1'b0);
    acc = last_acc;
    wait_out(N + LS, "single");
    check_sym(0, 1'b0, 0, 1'b0, "single");
    if (cap_i.size() >= N + LS) begin
      checks++;
      if (cap_edge[0] - acc !== 2) begin
        errors++;
        $display("FAIL single_latency: sop %0d edges after last accept, required 2", cap_edge[0] - acc);
      end
      checks++;
      if (cap_edge[N+LS-1] - cap_edge[0] !== N + LS - 1) begin
        errors++;
        $display("FAIL single_gapless: span %0d, required %0d", cap_edge[N+LS-1] - cap_edge[0], N + LS - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int total;
    clear_cap();
    stalls = 0;
    total = (N + LS) + (N + LL) + (N + LS);
    send_sym(N, 1'b0, 100, 1'b1, 1'b0);
    send_sym(N, 1'b1, 200, 1'b1, 1'b0);
    send_sym(N, 1'b0, 300, 1'b1, 1'b0);
    wait_out(total, "b2b");
    check_sym(0, 1'b0, 100, 1'b0, "b2b_sym0");
    check_sym(N + LS, 1'b1, 200, 1'b0, "b2b_sym1");
    check_sym(2 * N + LS + LL, 1'b0, 300, 1'b0, "b2b_sym2");
    checks++;
    if (!(stalls > 0)) begin
      errors++;
      $display("FAIL b2b_backpressure: got %0d stall cycles, required more than 0", stalls);
    end
    if (cap_i.size() >= total) begin
      checks++;
      if (cap_edge[total-1] - cap_edge[0] !== total - 1) begin
        errors++;
        $display("FAIL b2b_gapless: span %0d, required %0d", cap_edge[total-1] - cap_edge[0], total - 1);
      end
    end
  endtask

  task automatic test_sop_err();
    clear_cap();
    err_pulses = 0;
    send_sym(30, 1'b0, 1000, 1'b1, 1'b0);
    send_sym(N, 1'b1, 2000, 1'b1, 1'b0);
    wait_out(N + LL, "sop_err");
    checks++;
    if (err_pulses !== 1) begin
      errors++;
      $display("FAIL sop_err_pulse: got %0d pulses, required 1", err_pulses);
    end
    check_sym(0, 1'b1, 2000, 1'b0, "sop_err");
  endtask

  task automatic test_en_toggle();
    clear_cap();
    en_tog = 1'b1;
    phase = 0;
    send_sym(N, 1'b0, 400, 1'b1, 1'b0);
    wait_out(N + LS, "en_tog");
    en_tog = 1'b0;
    tick();
    check_sym(0, 1'b0, 400, 1'b0, "en_tog");
    if (cap_i.size() >= N + LS) begin
      checks++;
      if (cap_edge[N+LS-1] - cap_edge[0] !== 3 * (N + LS - 1)) begin
        errors++;
        $display("FAIL en_tog_stretch: span %0d, required %0d",
                 cap_edge[N+LS-1] - cap_edge[0], 3 * (N + LS - 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    clear_cap();
    send_sym(N, 1'b0, 600, 1'b1, 1'b0);
    b = 0;
    while (cap_i.size() < 40 && b < 500) begin
      tick();
      b++;
    end
    checks++;
    if (cap_i.size() < 40) begin
      errors++;
      $display("FAIL rst_mid_progress: got %0d samples, required 40", cap_i.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid/ready=%02b, required 00", {out_valid, in_ready});
    end
    tick();
    tick();
    rst = 1'b0;
    clear_cap();
    send_sym(5, 1'b0, 500, 1'b0, 1'b0);
    send_sym(N, 1'b1, 700, 1'b1, 1'b0);
    wait_out(N + LL, "rst_mid");
    check_sym(0, 1'b1, 700, 1'b0, "rst_mid");
  endtask

  task automatic test_extremes();
    clear_cap();
    send_sym(N, 1'b1, 0, 1'b1, 1'b1);
    wait_out(N + LL, "extreme");
    check_sym(0, 1'b1, 0, 1'b1, "extreme");
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    cp_mode = 1'b0;
    in_i = '0;
    in_q = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_sop_err();
    test_en_toggle();
    test_reset_mid();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
